// File: rtl/shift_rotate_pkg.sv
// Shared encodings for the shift/rotate unit: operation modes, FSM states,
// and a helper that classifies a mode as a real shift/rotate.
package shift_rotate_pkg;

  // Operation select. Codes 110 and 111 are reserved and behave as LOAD.
  typedef enum logic [2:0] {
    MODE_LOAD = 3'b000,
    MODE_SLL  = 3'b001,
    MODE_SRL  = 3'b010,
    MODE_SRA  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101
  } mode_e;

  // FSM state encoding, kept as plain constants for compatibility with
  // existing blocks that compare raw state values.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // True for modes that move bits. LOAD and the reserved codes return false.
  function automatic logic is_step_mode(input logic [2:0] m);
    return (m inside {MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR});
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step. Purely combinational; the top applies it once
// per clock while an operation is running.
module shift_step
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] q_out
);

  // Select the single-bit move for the requested operation.
  always_comb begin
    // NOTE: every output of an always_comb gets a value on every path;
    // the default here is what keeps this block from inferring a latch.
    q_out = q_in;
    case (mode)
      MODE_SLL: q_out = {q_in[WIDTH-2:0], 1'b0};
      MODE_SRL: q_out = {1'b0, q_in[WIDTH-1:1]};
      MODE_SRA: q_out = {q_in[WIDTH-1], q_in[WIDTH-1:1]};
      MODE_ROL: q_out = {q_in[WIDTH-2:0], q_in[WIDTH-1]};
      MODE_ROR: q_out = {q_in[0], q_in[WIDTH-1:1]};
      default:  q_out = q_in;
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit. A start in IDLE captures the operand, mode
// and distance; RUN then applies one 1-bit step per clock until the distance
// is used up, and DONE raises a single-cycle strobe before returning to IDLE.
module shift_rotate_unit
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_q;

  // One-bit step of the latched mode applied to the current result.
  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode  (mode_q),
    .q_in  (q_q),
    .q_out (step_q)
  );

  // Next-state, result and counter logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d    = din;
          mode_d = mode;
          cnt_d  = amt;
          if (is_step_mode(mode) && (amt != '0)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        q_d   = step_q;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        // Inputs, including start, are ignored for this cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset wins over start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_LOAD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule
